// File: rtl/led_row_scan_ctrl.sv
// LED panel row scan controller: shift a row of column data, blank, latch, then display it.
// Ports:
//   Inputs:  clk, rst (synchronous, active high), en, data_bit.
//   Outputs: data_row/data_col (frame-buffer address), sclk/sdata/latch/oe_n (column
//            drivers), dec_a/dec_e1/dec_e2/dec_e3 (row decoder), busy, frame_done.
// Optional feature: define LED_SCAN_BRIGHTNESS_EN to add input bright[7:0] for PWM dimming.
module led_row_scan_ctrl #(
    parameter int COLS        = 32,
    parameter int ROWS        = 8,
    parameter int ON_CYCLES   = 256,
    parameter int DEAD_CYCLES = 4,
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_bit,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [7:0]       bright,
`endif
    output logic [2:0]       data_row,
    output logic [COL_W-1:0] data_col,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             oe_n,
    output logic [2:0]       dec_a,
    output logic             dec_e1,
    output logic             dec_e2,
    output logic             dec_e3,
    output logic             busy,
    output logic             frame_done
);

    localparam int MAX_CNT = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_BLANK   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_DISPLAY = 3'd4;

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [2:0]       LAST_ROW  = 3'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_DEAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_ON   = CNT_W'(ON_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       row;
    logic [2:0]       row_next;
    logic             phase;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign row_next = (row == LAST_ROW) ? 3'd0 : row + 3'd1;
    assign cnt_inc  = cnt + CNT_W'(1);

`ifdef LED_SCAN_BRIGHTNESS_EN
    // On-time threshold captured at LATCH so a bright change mid-row cannot glitch it.
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] thr_next;
    assign thr_next = CNT_W'((32'(bright) * 32'(ON_CYCLES)) >> 8);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= 3'd0;
            phase      <= 1'b0;
            cnt        <= '0;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
            latch      <= 1'b0;
            oe_n       <= 1'b1;
            dec_a      <= 3'd0;
            dec_e1     <= 1'b1;
            dec_e2     <= 1'b1;
            dec_e3     <= 1'b0;
            data_row   <= 3'd0;
            data_col   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
            thr        <= '0;
`endif
        end else begin
            latch      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state    <= S_SHIFT;
                        busy     <= 1'b1;
                        data_row <= row;
                        data_col <= '0;
                        phase    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (!phase) begin
                        // Data settles while sclk is low; the rise comes next cycle.
                        sclk  <= 1'b0;
                        sdata <= data_bit;
                        phase <= 1'b1;
                    end else begin
                        sclk  <= 1'b1;
                        phase <= 1'b0;
                        if (data_col == LAST_COL) begin
                            state    <= S_BLANK;
                            cnt      <= '0;
                            data_col <= '0;
                        end else begin
                            data_col <= data_col + COL_W'(1);
                        end
                    end
                end
                S_BLANK: begin
                    sclk <= 1'b0;
                    oe_n <= 1'b1;
                    if (cnt == LAST_DEAD) begin
                        state <= S_LATCH;
                        latch <= 1'b1;
                        // Row address moves only while the panel is dark.
                        dec_a <= row;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_LATCH: begin
                    state  <= S_DISPLAY;
                    cnt    <= '0;
                    dec_e1 <= 1'b0;
                    dec_e2 <= 1'b0;
                    dec_e3 <= 1'b1;
`ifdef LED_SCAN_BRIGHTNESS_EN
                    thr    <= thr_next;
                    oe_n   <= (thr_next == '0);
`else
                    oe_n   <= 1'b0;
`endif
                end
                S_DISPLAY: begin
                    if (cnt == LAST_ON) begin
                        row        <= row_next;
                        frame_done <= (row == LAST_ROW);
                        data_row   <= row_next;
                        data_col   <= '0;
                        phase      <= 1'b0;
                        oe_n       <= 1'b1;
                        dec_e1     <= 1'b1;
                        dec_e2     <= 1'b1;
                        dec_e3     <= 1'b0;
                        state      <= en ? S_SHIFT : S_IDLE;
                        busy       <= en;
                    end else begin
                        cnt <= cnt_inc;
`ifdef LED_SCAN_BRIGHTNESS_EN
                        oe_n <= !(cnt_inc < thr);
`else
                        oe_n <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_row_scan_ctrl.sv
// Directed self-checking bench for led_row_scan_ctrl (default build, defaults parameters).
// Drives and samples on the falling clock edge.
module tb_led_row_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       data_bit;
    logic [2:0] data_row;
    logic [4:0] data_col;
    logic       sclk;
    logic       sdata;
    logic       latch;
    logic       oe_n;
    logic [2:0] dec_a;
    logic       dec_e1;
    logic       dec_e2;
    logic       dec_e3;
    logic       busy;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Alternating pixel pattern: column 0 is 1, column 1 is 0, ...
    assign data_bit = ~data_col[0];

    led_row_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_bit   (data_bit),
        .data_row   (data_row),
        .data_col   (data_col),
        .sclk       (sclk),
        .sdata      (sdata),
        .latch      (latch),
        .oe_n       (oe_n),
        .dec_a      (dec_a),
        .dec_e1     (dec_e1),
        .dec_e2     (dec_e2),
        .dec_e3     (dec_e3),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_latch(input int limit, output int cyc);
        cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (latch) begin
                cyc = i;
                return;
            end
        end
    endtask

    initial begin
        int rises, sd_bad, last_rise, latch_at, low, bad;
        int fd_cnt, fd_t0, fd_t1, nl, cyc;
        logic prev_sclk;
        logic [2:0] lat_rows [0:8];

        // Reset held for three cycles
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy), 0);
        check("rst_oe_n",   32'(oe_n), 1);
        check("rst_dec_en", 32'({dec_e1, dec_e2, dec_e3}), 32'(3'b110));
        check("rst_cols",   32'({sclk, sdata, latch, frame_done}), 0);
        check("rst_addr",   32'({dec_a, data_row, data_col}), 0);

        // First row: shifting, dead time, latch
        rst = 1'b0;
        en  = 1'b1;
        rises = 0; sd_bad = 0; last_rise = -1; latch_at = -1;
        prev_sclk = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sclk && !prev_sclk) begin
                if (sdata !== (rises % 2 == 0)) sd_bad++;
                rises++;
                last_rise = i;
            end
            prev_sclk = sclk;
            if (latch) begin
                latch_at = i;
                break;
            end
        end
        check("row0_latch_seen", 32'(latch_at >= 0), 1);
        check("row0_sclk_rises", 32'(rises), 32);
        check("row0_sdata_bad",  32'(sd_bad), 0);
        check("row0_dead_gap",   32'(latch_at - last_rise), 4);
        check("row0_dec_a",      32'(dec_a), 0);

        // Row 0 on-time: oe_n low 256 cycles with decoder at row 0
        low = 0; bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!oe_n) begin
                low++;
                if (dec_a !== 3'd0 || {dec_e1, dec_e2, dec_e3} !== 3'b001) bad++;
            end
        end
        check("row0_oe_low", 32'(low), 256);
        check("row0_dec_bad", 32'(bad), 0);

        // Continuous scan: row order, frame period, blanking discipline
        fd_cnt = 0; fd_t0 = 0; fd_t1 = 0; nl = 0; bad = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!oe_n && (!dec_e3 || dec_e1 || dec_e2 || latch || sclk)) bad++;
            if (latch && nl < 9) begin
                lat_rows[nl] = dec_a;
                nl++;
            end
            if (frame_done) begin
                if (fd_cnt == 0) fd_t0 = i;
                else fd_t1 = i;
                fd_cnt++;
                if (fd_cnt == 2) break;
            end
        end
        check("scan_fd_count", 32'(fd_cnt), 2);
        check("scan_fd_period", 32'(fd_t1 - fd_t0), 2600);
        check("scan_latches", 32'(nl), 9);
        check("scan_oe_viol", 32'(bad), 0);
        bad = 0;
        for (int k = 0; k < 9; k++)
            if (lat_rows[k] !== 3'((k + 1) % 8)) bad++;
        check("scan_row_order", 32'(bad), 0);

        // en dropped mid-shift of row 3
        cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (data_row == 3'd3 && data_col == 5'd10) begin
                cyc = i;
                break;
            end
        end
        check("drop_reach_row3", 32'(cyc >= 0), 1);
        en = 1'b0;
        wait_latch(200, cyc);
        check("drop_latch_seen", 32'(cyc >= 0), 1);
        check("drop_dec_a", 32'(dec_a), 3);
        low = 0; cyc = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!oe_n) low++;
            if (!busy) begin
                cyc = i;
                break;
            end
        end
        check("drop_idle_seen", 32'(cyc >= 0), 1);
        check("drop_oe_low", 32'(low), 256);
        check("drop_data_row", 32'(data_row), 4);
        repeat (20) @(negedge clk);
        check("drop_stays_idle", 32'({busy, oe_n, sclk}), 32'(3'b010));
        en = 1'b1;
        wait_latch(200, cyc);
        check("resume_latch_seen", 32'(cyc >= 0), 1);
        check("resume_dec_a", 32'(dec_a), 4);

        // Reset in the middle of row 5's display
        wait_latch(1000, cyc);
        check("row5_latch_seen", 32'(cyc >= 0), 1);
        check("row5_dec_a", 32'(dec_a), 5);
        repeat (50) @(negedge clk);
        check("row5_displaying", 32'(oe_n), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_oe_n", 32'(oe_n), 1);
        check("midrst_dec_en", 32'({dec_e1, dec_e2, dec_e3}), 32'(3'b110));
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        wait_latch(200, cyc);
        check("restart_latch_seen", 32'(cyc >= 0), 1);
        check("restart_dec_a", 32'(dec_a), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
